// File: rtl/wbuf_pkg.sv
// Shared types for the write-buffer drain path; also types the parent's fifo_v3 dtype.
package wbuf_pkg;

   localparam int unsigned WBUF_ADDR_WIDTH = 32;
   localparam int unsigned WBUF_DATA_WIDTH = 32;
   localparam int unsigned WBUF_BE_WIDTH   = WBUF_DATA_WIDTH / 8;

   typedef struct packed {
      logic [WBUF_ADDR_WIDTH-1:0] addr;
      logic [WBUF_DATA_WIDTH-1:0] wdata;
      logic [WBUF_BE_WIDTH-1:0]   be;
   } wbuf_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } wbuf_state_e;

endpackage

// File: rtl/wbuf_drain.sv
// Pops store entries from the write-buffer FIFO and issues them in order on the
// req/gnt/rvalid data bus, bounding the number of granted-but-unacked writes.
//
// state | meaning
// IDLE  | no request on the bus
// ISSUE | request registers driven on the bus, waiting for gnt
module wbuf_drain
   import wbuf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = WBUF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH      = WBUF_DATA_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = 2,
   localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    hold_i,
   input  logic                    fifo_empty_i,
   input  wbuf_entry_t             fifo_data_i,
   output logic                    fifo_pop_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   output logic [CNT_W-1:0]        outstanding_o,
   output logic                    idle_o,
   output logic                    ack_err_o
);

   localparam logic [CNT_W:0]      MAX_CNT    = (CNT_W + 1)'(MAX_OUTSTANDING);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH - 2){1'b1}}, 2'b00};

   wbuf_state_e             state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] be_q;
   logic [CNT_W-1:0]        outstanding_q;
   logic                    ack_err_q;

   logic           gnt_eff;
   logic [CNT_W:0] occupancy;
   logic           slot_free;
   logic           take;
   logic           cnt_dec;
   logic           stray_ack;

   // A slot freed by an rvalid this cycle is not reused until next cycle.
   assign gnt_eff   = (state_q == ISSUE) & mem_gnt_i;
   assign occupancy = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, gnt_eff};
   assign slot_free = occupancy < MAX_CNT;
   assign take      = ~rst_i & ~fifo_empty_i & ~hold_i & slot_free &
                      ((state_q == IDLE) | mem_gnt_i);
   assign stray_ack = mem_rvalid_i & (outstanding_q == '0);
   assign cnt_dec   = mem_rvalid_i & ~stray_ack;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         be_q          <= '0;
         outstanding_q <= '0;
         ack_err_q     <= 1'b0;
      end else begin
         if (take) begin
            state_q <= ISSUE;
            addr_q  <= fifo_data_i.addr & ALIGN_MASK;
            wdata_q <= fifo_data_i.wdata;
            be_q    <= fifo_data_i.be;
         end else if (gnt_eff) begin
            state_q <= IDLE;
         end

         case ({gnt_eff, cnt_dec})
            2'b10:   outstanding_q <= outstanding_q + 1'b1;
            2'b01:   outstanding_q <= outstanding_q - 1'b1;
            default: outstanding_q <= outstanding_q;
         endcase

         if (stray_ack) begin
            ack_err_q <= 1'b1;
         end
      end
   end

   assign fifo_pop_o    = take;
   assign mem_req_o     = (state_q == ISSUE);
   assign mem_we_o      = (state_q == ISSUE);
   assign mem_addr_o    = addr_q;
   assign mem_wdata_o   = wdata_q;
   assign mem_be_o      = be_q;
   assign outstanding_o = outstanding_q;
   assign idle_o        = fifo_empty_i & (state_q == IDLE) & (outstanding_q == '0);
   assign ack_err_o     = ack_err_q;

endmodule
